alu_issue_ctrl: RTL and testbench

Multi-cycle issue controller that drives the datapath ALU's operand, control and shift-amount inputs and consumes its result and zero flag. It accepts one MIPS instruction word with its register-file operands through a valid/ready handshake. It decodes the opcode and funct into the 4-bit ALU control code, holds the ALU inputs stable for a programmable number of execute cycles, and captures the result. It then presents a one-cycle write-back or branch outcome. It sits between instruction fetch/register read and the register-file write port.

---
 rtl/alu_issue_ctrl.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Multi-cycle issue controller that sits between fetch/register read and the
//   register-file write port. It accepts one MIPS instruction with its operands,
//   decodes it into ALU drive signals, holds them for EXEC_CYCLES cycles, captures
//   the ALU result and presents a single-cycle completion strobe.
//
// Ports
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   instr_valid / instr_ready       instruction handshake (ready only in IDLE)
//   instr, rs_data, rt_data         instruction word and register operands
//   alu_in_one, alu_in_two          ALU operands (registered, stable in EXECUTE)
//   alu_control, shift_amount       ALU operation code and shift amount
//   alu_result, alu_zero            combinational ALU outputs
//   wb_valid, wb_reg, wb_data       write-back strobe, destination and data
//   branch_valid, branch_taken      beq resolution strobe and outcome
//   illegal                         undecodable-instruction strobe
//
// State table
//   state      | meaning
//   S_IDLE     | ready for a new instruction; operands latched on handshake
//   S_DECODE   | ALU drive signals and destination registered
//   S_EXECUTE  | ALU inputs held; down-counter runs to terminal count 0
//   S_COMPLETE | one-cycle wb_valid / branch_valid / illegal strobe
module alu_issue_ctrl #(
  parameter logic [3:0] EXEC_CYCLES = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_in_one,
  output logic [31:0] alu_in_two,
  output logic [3:0]  alu_control,
  output logic [4:0]  shift_amount,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        branch_valid,
  output logic        branch_taken,
  output logic        illegal
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXECUTE, S_COMPLETE} state_t;
  typedef enum logic [1:0] {K_WB, K_BRANCH, K_ILLEGAL} kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] rs_q, rs_d;
  logic [31:0] rt_q, rt_d;
  logic [31:0] alu_in_one_q, alu_in_one_d;
  logic [31:0] alu_in_two_q, alu_in_two_d;
  logic [3:0]  alu_control_q, alu_control_d;
  logic [4:0]  shift_amount_q, shift_amount_d;
  logic [4:0]  dest_q, dest_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_reg_q, wb_reg_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        branch_valid_q, branch_valid_d;
  logic        branch_taken_q, branch_taken_d;
  logic        illegal_q, illegal_d;

  // decoded fields of the latched instruction
  logic [5:0]  opcode_f, funct_f;
  logic [4:0]  rt_f, rd_f, shamt_f;
  logic [31:0] imm_sext, imm_zext;
  logic        unused_rs_field;

  assign opcode_f = instr_q[31:26];
  assign rt_f     = instr_q[20:16];
  assign rd_f     = instr_q[15:11];
  assign shamt_f  = instr_q[10:6];
  assign funct_f  = instr_q[5:0];
  assign imm_sext = {{16{instr_q[15]}}, instr_q[15:0]};
  assign imm_zext = {16'd0, instr_q[15:0]};
  // rs arrives as data; its register number is not needed here
  assign unused_rs_field = ^instr_q[25:21];

  kind_t       dec_kind;
  logic [3:0]  dec_ctrl;
  logic [31:0] dec_a, dec_b;
  logic [4:0]  dec_sh, dec_dest;

  always_comb begin
    dec_kind = K_ILLEGAL;
    dec_ctrl = 4'b1111;
    dec_a    = '0;
    dec_b    = '0;
    dec_sh   = '0;
    dec_dest = '0;
    case (opcode_f)
      6'h00: begin
        dec_kind = K_WB;
        dec_a    = rs_q;
        dec_b    = rt_q;
        dec_dest = rd_f;
        case (funct_f)
          6'h20: dec_ctrl = 4'b0000;
          6'h22: dec_ctrl = 4'b0001;
          6'h27: dec_ctrl = 4'b0010;
          6'h24: dec_ctrl = 4'b0101;
          6'h25: dec_ctrl = 4'b0110;
          6'h2A: dec_ctrl = 4'b0111;
          // shifts operate on rt
          6'h00: begin
            dec_ctrl = 4'b0011;
            dec_a    = rt_q;
            dec_sh   = shamt_f;
          end
          6'h02: begin
            dec_ctrl = 4'b0100;
            dec_a    = rt_q;
            dec_sh   = shamt_f;
          end
          default: begin
            dec_kind = K_ILLEGAL;
            dec_ctrl = 4'b1111;
            dec_a    = '0;
            dec_b    = '0;
            dec_dest = '0;
          end
        endcase
      end
      6'h08: begin
        dec_kind = K_WB;
        dec_ctrl = 4'b0000;
        dec_a    = rs_q;
        dec_b    = imm_sext;
        dec_dest = rt_f;
      end
      6'h0A: begin
        dec_kind = K_WB;
        dec_ctrl = 4'b0111;
        dec_a    = rs_q;
        dec_b    = imm_sext;
        dec_dest = rt_f;
      end
      6'h0C: begin
        dec_kind = K_WB;
        dec_ctrl = 4'b0101;
        dec_a    = rs_q;
        dec_b    = imm_zext;
        dec_dest = rt_f;
      end
      6'h0D: begin
        dec_kind = K_WB;
        dec_ctrl = 4'b0110;
        dec_a    = rs_q;
        dec_b    = imm_zext;
        dec_dest = rt_f;
      end
      6'h04: begin
        dec_kind = K_BRANCH;
        dec_ctrl = 4'b0001;
        dec_a    = rs_q;
        dec_b    = rt_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    instr_d        = instr_q;
    rs_d           = rs_q;
    rt_d           = rt_q;
    alu_in_one_d   = alu_in_one_q;
    alu_in_two_d   = alu_in_two_q;
    alu_control_d  = alu_control_q;
    shift_amount_d = shift_amount_q;
    dest_d         = dest_q;
    cnt_d          = cnt_q;
    wb_reg_d       = wb_reg_q;
    wb_data_d      = wb_data_q;
    branch_taken_d = branch_taken_q;
    wb_valid_d     = 1'b0;
    branch_valid_d = 1'b0;
    illegal_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          rs_d    = rs_data;
          rt_d    = rt_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_in_one_d   = dec_a;
        alu_in_two_d   = dec_b;
        alu_control_d  = dec_ctrl;
        shift_amount_d = dec_sh;
        dest_d         = dec_dest;
        kind_d         = dec_kind;
        cnt_d          = EXEC_CYCLES - 4'd1;
        if (dec_kind == K_ILLEGAL) begin
          illegal_d = 1'b1;
          state_d   = S_COMPLETE;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_COMPLETE;
          if (kind_q == K_BRANCH) begin
            branch_valid_d = 1'b1;
            branch_taken_d = alu_zero;
          end else begin
            // writes to $zero are computed but never strobed
            wb_valid_d = (dest_q != 5'd0);
            wb_reg_d   = dest_q;
            wb_data_d  = alu_result;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_COMPLETE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      kind_q         <= K_ILLEGAL;
      instr_q        <= '0;
      rs_q           <= '0;
      rt_q           <= '0;
      alu_in_one_q   <= '0;
      alu_in_two_q   <= '0;
      alu_control_q  <= 4'b1111;
      shift_amount_q <= '0;
      dest_q         <= '0;
      cnt_q          <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_q       <= '0;
      wb_data_q      <= '0;
      branch_valid_q <= 1'b0;
      branch_taken_q <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      instr_q        <= instr_d;
      rs_q           <= rs_d;
      rt_q           <= rt_d;
      alu_in_one_q   <= alu_in_one_d;
      alu_in_two_q   <= alu_in_two_d;
      alu_control_q  <= alu_control_d;
      shift_amount_q <= shift_amount_d;
      dest_q         <= dest_d;
      cnt_q          <= cnt_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_q       <= wb_reg_d;
      wb_data_q      <= wb_data_d;
      branch_valid_q <= branch_valid_d;
      branch_taken_q <= branch_taken_d;
      illegal_q      <= illegal_d;
    end
  end

  assign instr_ready  = (state_q == S_IDLE);
  assign alu_in_one   = alu_in_one_q;
  assign alu_in_two   = alu_in_two_q;
  assign alu_control  = alu_control_q;
  assign shift_amount = shift_amount_q;
  assign wb_valid     = wb_valid_q;
  assign wb_reg       = wb_reg_q;
  assign wb_data      = wb_data_q;
  assign branch_valid = branch_valid_q;
  assign branch_taken = branch_taken_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (EXEC_CYCLES 1 and 4) share stimulus.
// A behavioural ALU closes the loop; an instruction-level model predicts drive
// values, results and strobe timing, checked every cycle.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, instr_valid;
  logic [31:0] instr, rs_data, rt_data;
  logic        rdy[2], zf[2], wbv[2], brv[2], brt[2], ill[2];
  logic [31:0] a_in[2], b_in[2], res[2], wbd[2];
  logic [3:0]  ctrl[2];
  logic [4:0]  sh[2], wbr[2];

  function automatic logic [31:0] alu_f(logic [3:0] c, logic [31:0] x, logic [31:0] y,
                                        logic [4:0] s);
    case (c)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return ~x;
      4'd3: return x << s;
      4'd4: return x >> s;
      4'd5: return x & y;
      4'd6: return x | y;
      4'd7: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign res[0] = alu_f(ctrl[0], a_in[0], b_in[0], sh[0]);
  assign res[1] = alu_f(ctrl[1], a_in[1], b_in[1], sh[1]);
  assign zf[0]  = (res[0] == 32'd0);
  assign zf[1]  = (res[1] == 32'd0);

  alu_issue_ctrl #(.EXEC_CYCLES(4'd1)) u_dut1 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(rdy[0]),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_in_one(a_in[0]), .alu_in_two(b_in[0]), .alu_control(ctrl[0]),
    .shift_amount(sh[0]), .alu_result(res[0]), .alu_zero(zf[0]),
    .wb_valid(wbv[0]), .wb_reg(wbr[0]), .wb_data(wbd[0]),
    .branch_valid(brv[0]), .branch_taken(brt[0]), .illegal(ill[0]));

  alu_issue_ctrl #(.EXEC_CYCLES(4'd4)) u_dut4 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(rdy[1]),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_in_one(a_in[1]), .alu_in_two(b_in[1]), .alu_control(ctrl[1]),
    .shift_amount(sh[1]), .alu_result(res[1]), .alu_zero(zf[1]),
    .wb_valid(wbv[1]), .wb_reg(wbr[1]), .wb_data(wbd[1]),
    .branch_valid(brv[1]), .branch_taken(brt[1]), .illegal(ill[1]));

  // kind: 0 write-back, 1 branch, 2 illegal
  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [4:0]  dest;
    logic [31:0] res;
    logic        taken;
  } exp_t;

  function automatic exp_t model(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt);
    exp_t m;
    logic [5:0] op, fn;
    logic [31:0] se, ze;
    op = ins[31:26];
    fn = ins[5:0];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'd0, ins[15:0]};
    m = '0;
    m.kind = 2'd2;
    m.ctrl = 4'hF;
    if (op == 6'h00) begin
      m.kind = 2'd0; m.dest = ins[15:11]; m.a = rs; m.b = rt;
      case (fn)
        6'h20: begin m.ctrl = 4'd0; m.res = rs + rt; end
        6'h22: begin m.ctrl = 4'd1; m.res = rs - rt; end
        6'h27: begin m.ctrl = 4'd2; m.res = ~rs; end
        6'h24: begin m.ctrl = 4'd5; m.res = rs & rt; end
        6'h25: begin m.ctrl = 4'd6; m.res = rs | rt; end
        6'h2A: begin m.ctrl = 4'd7; m.res = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; end
        6'h00: begin m.ctrl = 4'd3; m.a = rt; m.sh = ins[10:6]; m.res = rt << ins[10:6]; end
        6'h02: begin m.ctrl = 4'd4; m.a = rt; m.sh = ins[10:6]; m.res = rt >> ins[10:6]; end
        default: begin m = '0; m.kind = 2'd2; m.ctrl = 4'hF; end
      endcase
    end else begin
      case (op)
        6'h08: begin m.kind = 0; m.ctrl = 4'd0; m.a = rs; m.b = se; m.dest = ins[20:16]; m.res = rs + se; end
        6'h0A: begin m.kind = 0; m.ctrl = 4'd7; m.a = rs; m.b = se; m.dest = ins[20:16];
                     m.res = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0; end
        6'h0C: begin m.kind = 0; m.ctrl = 4'd5; m.a = rs; m.b = ze; m.dest = ins[20:16]; m.res = rs & ze; end
        6'h0D: begin m.kind = 0; m.ctrl = 4'd6; m.a = rs; m.b = ze; m.dest = ins[20:16]; m.res = rs | ze; end
        6'h04: begin m.kind = 1; m.ctrl = 4'd1; m.a = rs; m.b = rt; m.taken = (rs == rt); end
        default: ;
      endcase
    end
    return m;
  endfunction

  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  exp_t ex;
  bit   busy[2];
  int   acc_e[2], stb_e[2], kill_e[2];
  int   obs_lat[2];
  bit   obs_wb[2];
  logic [3:0]  obs_ctrl[2];
  logic [31:0] obs_a[2], obs_b[2];
  logic [4:0]  obs_sh[2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // per-cycle comparison against the model
  always @(posedge clk) begin
    #2;
    for (int d = 0; d < 2; d++) begin
      int ee, ec;
      bit infl, stb;
      ee = edge_cnt;
      ec = (d == 0) ? 1 : 4;
      infl = busy[d] && ee >= acc_e[d] && ee <= stb_e[d] && ee < kill_e[d];
      stb  = infl && ee == stb_e[d];
      chk($sformatf("ready[%0d]@%0d", d, ee), {31'd0, rdy[d]}, {31'd0, !infl});
      chk($sformatf("wb_valid[%0d]@%0d", d, ee), {31'd0, wbv[d]},
          {31'd0, stb && ex.kind == 2'd0 && ex.dest != 5'd0});
      chk($sformatf("branch_valid[%0d]@%0d", d, ee), {31'd0, brv[d]},
          {31'd0, stb && ex.kind == 2'd1});
      chk($sformatf("illegal[%0d]@%0d", d, ee), {31'd0, ill[d]},
          {31'd0, stb && ex.kind == 2'd2});
      if (stb && ex.kind == 2'd0 && ex.dest != 5'd0) begin
        chk($sformatf("wb_reg[%0d]", d), {27'd0, wbr[d]}, {27'd0, ex.dest});
        chk($sformatf("wb_data[%0d]", d), wbd[d], ex.res);
      end
      if (stb && ex.kind == 2'd1)
        chk($sformatf("branch_taken[%0d]", d), {31'd0, brt[d]}, {31'd0, ex.taken});
      if (infl && ex.kind != 2'd2 && ee >= acc_e[d] + 1 && ee <= acc_e[d] + ec) begin
        chk($sformatf("alu_control[%0d]@%0d", d, ee), {28'd0, ctrl[d]}, {28'd0, ex.ctrl});
        chk($sformatf("alu_in_one[%0d]@%0d", d, ee), a_in[d], ex.a);
        chk($sformatf("alu_in_two[%0d]@%0d", d, ee), b_in[d], ex.b);
        chk($sformatf("shift_amount[%0d]@%0d", d, ee), {27'd0, sh[d]}, {27'd0, ex.sh});
      end
      if (infl && ex.kind == 2'd2 && ee == acc_e[d] + 1)
        chk($sformatf("illegal_ctrl[%0d]", d), {28'd0, ctrl[d]}, 32'hF);
      if (wbv[d] || brv[d] || ill[d]) obs_lat[d] = ee - acc_e[d] + 1;
      if (wbv[d]) obs_wb[d] = 1'b1;
      if (ee == acc_e[d] + 1) begin
        obs_ctrl[d] = ctrl[d];
        obs_a[d]    = a_in[d];
        obs_b[d]    = b_in[d];
        obs_sh[d]   = sh[d];
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    int n;
    @(negedge clk);
    instr = ins; rs_data = rs; rt_data = rt; instr_valid = 1'b1;
    @(posedge clk);
    #1;
    n = edge_cnt;
    instr_valid = 1'b0;
    ex = model(ins, rs, rt);
    for (int d = 0; d < 2; d++) begin
      busy[d]    = 1'b1;
      acc_e[d]   = n;
      stb_e[d]   = n + 1 + ((ex.kind == 2'd2) ? 0 : ((d == 0) ? 1 : 4));
      kill_e[d]  = 32'h7fffffff;
      obs_lat[d] = 0;
      obs_wb[d]  = 1'b0;
    end
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while ((busy[0] && edge_cnt <= stb_e[0] && edge_cnt < kill_e[0]) ||
           (busy[1] && edge_cnt <= stb_e[1] && edge_cnt < kill_e[1])) begin
      @(posedge clk);
      #3;
      guard++;
      if (guard > 40) begin
        checks++;
        errors++;
        $display("FAIL wait_done: got no completion after %0d cycles expected <= 40", guard);
        break;
      end
    end
  endtask

  function automatic logic [31:0] rtype(logic [4:0] rt, logic [4:0] rd, logic [4:0] sa,
                                        logic [5:0] fn);
    return {6'h00, 5'd1, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rt, logic [15:0] imm);
    return {op, 5'd1, rt, imm};
  endfunction

  logic [31:0] v_ins[8], v_rs[8], v_rt[8], v_res[8];
  logic [4:0]  v_rd[8];
  int n0;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = '0; rs_data = '0; rt_data = '0;
    for (int d = 0; d < 2; d++) begin
      busy[d] = 1'b0; acc_e[d] = 0; stb_e[d] = 0; kill_e[d] = 32'h7fffffff;
    end
    ex = '0;
    repeat (2) @(posedge clk);
    #3;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready[%0d]", d), {31'd0, rdy[d]}, 32'd1);
      chk($sformatf("rst_ctrl[%0d]", d), {28'd0, ctrl[d]}, 32'hF);
      chk($sformatf("rst_a[%0d]", d), a_in[d], 32'd0);
      chk($sformatf("rst_b[%0d]", d), b_in[d], 32'd0);
      chk($sformatf("rst_sh[%0d]", d), {27'd0, sh[d]}, 32'd0);
      chk($sformatf("rst_wb[%0d]", d), {27'd0, wbr[d]}, 32'd0);
      chk($sformatf("rst_wbd[%0d]", d), wbd[d], 32'd0);
      chk($sformatf("rst_strobes[%0d]", d), {28'd0, wbv[d], brv[d], ill[d], brt[d]}, 32'd0);
    end
    reset = 1'b0;

    // add rd=3, 5+7
    issue(rtype(5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7);
    wait_done();
    chk("add_ctrl", {28'd0, obs_ctrl[0]}, 32'h0);
    chk("add_lat1", obs_lat[0], 32'd3);
    chk("add_lat4", obs_lat[1], 32'd6);
    chk("add_wbreg", {27'd0, wbr[0]}, 32'd3);
    chk("add_wbdata", wbd[0], 32'd12);
    chk("add_wbdata4", wbd[1], 32'd12);

    // sll rd=2, rt=1, shamt=4
    issue(rtype(5'd6, 5'd2, 5'd4, 6'h00), 32'hDEAD, 32'h1);
    wait_done();
    chk("sll_sh", {27'd0, obs_sh[0]}, 32'd4);
    chk("sll_a", obs_a[0], 32'h1);
    chk("sll_wbdata", wbd[0], 32'h10);

    // addi rt=4, rs=10, imm=-1
    issue(itype(6'h08, 5'd4, 16'hFFFF), 32'd10, 32'd0);
    wait_done();
    chk("addi_b", obs_b[0], 32'hFFFFFFFF);
    chk("addi_wbdata", wbd[0], 32'd9);
    chk("addi_wbreg", {27'd0, wbr[0]}, 32'd4);

    // ori with imm=0x8000
    issue(itype(6'h0D, 5'd9, 16'h8000), 32'h1234, 32'd0);
    wait_done();
    chk("ori_b", obs_b[0], 32'h00008000);
    chk("ori_wbdata", wbd[0], 32'h00009234);

    // beq equal, then unequal
    issue(itype(6'h04, 5'd2, 16'h0010), 32'h55, 32'h55);
    wait_done();
    chk("beq_eq_taken", {31'd0, brt[0]}, 32'd1);
    chk("beq_eq_nowb", {31'd0, obs_wb[0]}, 32'd0);
    issue(itype(6'h04, 5'd2, 16'h0010), 32'h55, 32'h56);
    wait_done();
    chk("beq_ne_taken", {31'd0, brt[0]}, 32'd0);

    // illegal opcode and illegal funct
    issue({6'h3F, 26'h0}, 32'd1, 32'd2);
    wait_done();
    chk("ill_lat1", obs_lat[0], 32'd2);
    chk("ill_lat4", obs_lat[1], 32'd2);
    chk("ill_ctrl", {28'd0, obs_ctrl[0]}, 32'hF);
    issue(rtype(5'd2, 5'd3, 5'd0, 6'h3F), 32'd1, 32'd2);
    wait_done();
    chk("illfn_lat", obs_lat[0], 32'd2);

    // add to $zero
    issue(rtype(5'd2, 5'd0, 5'd0, 6'h20), 32'd5, 32'd7);
    wait_done();
    chk("rd0_nowb", {31'd0, obs_wb[0]}, 32'd0);
    chk("rd0_nowb4", {31'd0, obs_wb[1]}, 32'd0);

    // remaining operations with hand-computed results
    v_ins[0] = rtype(5'd2, 5'd7, 5'd0, 6'h22);  v_rs[0] = 32'd10;       v_rt[0] = 32'd3;
    v_res[0] = 32'd7;        v_rd[0] = 5'd7;
    v_ins[1] = rtype(5'd2, 5'd8, 5'd0, 6'h27);  v_rs[1] = 32'h0000FFFF; v_rt[1] = 32'd0;
    v_res[1] = 32'hFFFF0000; v_rd[1] = 5'd8;
    v_ins[2] = rtype(5'd2, 5'd9, 5'd0, 6'h24);  v_rs[2] = 32'hF0F0;     v_rt[2] = 32'hFF00;
    v_res[2] = 32'hF000;     v_rd[2] = 5'd9;
    v_ins[3] = rtype(5'd2, 5'd10, 5'd0, 6'h25); v_rs[3] = 32'hF0F0;     v_rt[3] = 32'h0F0F;
    v_res[3] = 32'hFFFF;     v_rd[3] = 5'd10;
    v_ins[4] = rtype(5'd2, 5'd11, 5'd0, 6'h2A); v_rs[4] = 32'hFFFFFFFD; v_rt[4] = 32'd2;
    v_res[4] = 32'd1;        v_rd[4] = 5'd11;
    v_ins[5] = rtype(5'd2, 5'd12, 5'd31, 6'h02); v_rs[5] = 32'd0;       v_rt[5] = 32'h80000000;
    v_res[5] = 32'd1;        v_rd[5] = 5'd12;
    v_ins[6] = itype(6'h0C, 5'd13, 16'h8001);   v_rs[6] = 32'hFFFFFFFF; v_rt[6] = 32'd0;
    v_res[6] = 32'h8001;     v_rd[6] = 5'd13;
    v_ins[7] = itype(6'h0A, 5'd14, 16'hFFFF);   v_rs[7] = 32'd5;        v_rt[7] = 32'd0;
    v_res[7] = 32'd0;        v_rd[7] = 5'd14;
    for (int i = 0; i < 8; i++) begin
      issue(v_ins[i], v_rs[i], v_rt[i]);
      wait_done();
      chk($sformatf("vec%0d_wbdata", i), wbd[1], v_res[i]);
      chk($sformatf("vec%0d_wbreg", i), {27'd0, wbr[1]}, {27'd0, v_rd[i]});
    end

    // reset in the middle of EXECUTE on the 4-cycle instance
    issue(rtype(5'd2, 5'd5, 5'd0, 6'h20), 32'd1, 32'd2);
    n0 = acc_e[0];
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    kill_e[0] = n0 + 3;
    kill_e[1] = n0 + 3;
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    chk("midrst_ready", {31'd0, rdy[1]}, 32'd1);
    chk("midrst_ctrl", {28'd0, ctrl[1]}, 32'hF);
    chk("midrst_a", a_in[1], 32'd0);
    chk("midrst_wbd", wbd[1], 32'd0);
    repeat (6) @(posedge clk);
    #3;
    chk("midrst_nostrobe", {31'd0, obs_wb[1]}, 32'd0);
    busy[0] = 1'b0;
    busy[1] = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
